// File: rtl/rs232_pkg.sv
// Shared register map, status bit positions and FSM encoding for the RS232 register block.
// Also imported by the RSA wrapper so that both sides decode the same addresses.
package rs232_pkg;

  localparam int RX_BASE     = 0;
  localparam int TX_BASE     = 4;
  localparam int STATUS_BASE = 8;

  localparam int TX_OK_BIT  = 6;
  localparam int RX_OK_BIT  = 7;
  localparam int TX_OVF_BIT = 8;
  localparam int RX_UDF_BIT = 9;

  typedef enum logic {IDLE, RESP} state_t;

endpackage

// File: rtl/rs232_avm_slave_byte_fifo.sv
// Byte FIFO with power-of-2 depth; head is combinational from the read pointer, zero when empty.
// Push when full and pop when empty are ignored, so callers may request them freely.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rs232_avm_slave.sv
// Avalon-MM RS232 register block: RX/TX byte FIFOs plus sticky status, two cycles per access.
// Side effects and readdata are committed on the accept edge in IDLE; waitrequest drops in RESP.
module rs232_avm_slave #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 5
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  input  logic [ADDR_W-1:0] avm_address,
  input  logic              avm_read,
  input  logic              avm_write,
  input  logic [31:0]       avm_writedata,
  output logic [31:0]       avm_readdata,
  output logic              avm_waitrequest,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  import rs232_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t       state;
  logic         tx_overflow;
  logic         rx_underflow;
  logic         accept;
  logic         is_rd;
  logic         hit_rx;
  logic         hit_tx;
  logic         hit_status;
  logic         rx_pop;
  logic         tx_push;
  logic         rx_full;
  logic         rx_empty;
  logic         tx_full;
  logic         tx_empty;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic [7:0]   rx_head;
  logic [31:0]  status_word;
  logic [31:0]  rd_word;
  logic         unused_bits;

  assign unused_bits = ^{avm_writedata[31:10], rx_count, tx_count};

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;

  always_comb begin
    accept      = (state == IDLE) && (avm_read || avm_write);
    is_rd       = avm_read && !avm_write;
    hit_rx      = (avm_address == ADDR_W'(RX_BASE));
    hit_tx      = (avm_address == ADDR_W'(TX_BASE));
    hit_status  = (avm_address == ADDR_W'(STATUS_BASE));
    rx_pop      = accept && is_rd && hit_rx && !rx_empty;
    tx_push     = accept && avm_write && hit_tx && !tx_full;

    // Occupancy is taken before this edge's line-side push/pop.
    status_word             = '0;
    status_word[RX_OK_BIT]  = !rx_empty;
    status_word[TX_OK_BIT]  = !tx_full;
    status_word[TX_OVF_BIT] = tx_overflow;
    status_word[RX_UDF_BIT] = rx_underflow;

    rd_word = '0;
    if (is_rd && hit_rx)     rd_word = {24'h0, rx_head};
    if (is_rd && hit_status) rd_word = status_word;
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state           <= IDLE;
      avm_waitrequest <= 1'b1;
      avm_readdata    <= '0;
      tx_overflow     <= 1'b0;
      rx_underflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state           <= RESP;
            avm_waitrequest <= 1'b0;
            avm_readdata    <= rd_word;
            if (avm_write && hit_tx && tx_full) tx_overflow <= 1'b1;
            if (avm_write && hit_status && avm_writedata[TX_OVF_BIT]) tx_overflow <= 1'b0;
            if (is_rd && hit_rx && rx_empty) rx_underflow <= 1'b1;
            if (avm_write && hit_status && avm_writedata[RX_UDF_BIT]) rx_underflow <= 1'b0;
          end
        end
        RESP: begin
          state           <= IDLE;
          avm_waitrequest <= 1'b1;
        end
        default: begin
          state           <= IDLE;
          avm_waitrequest <= 1'b1;
        end
      endcase
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk       (avm_clk),
    .rst       (avm_rst),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .head      (rx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (avm_clk),
    .rst       (avm_rst),
    .push      (tx_push),
    .push_data (avm_writedata[7:0]),
    .pop       (tx_valid && tx_ready),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (tx_data)
  );

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Randomized and directed checks of rs232_avm_slave against a queue-based register model.
module tb_rs232_avm_slave;

  localparam int DEPTH = 16;

  logic        avm_clk;
  logic        avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_rx[$];
  logic [7:0] q_tx[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  int fed, got, last, cyc, fc;
  logic [4:0] cur;

  rs232_avm_slave #(.FIFO_DEPTH(DEPTH), .ADDR_W(5)) dut (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready)
  );

  initial avm_clk = 1'b0;
  always #5 avm_clk = ~avm_clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [31:0] status_model();
    logic [31:0] s;
    s    = 32'h0;
    s[9] = m_udf;
    s[8] = m_ovf;
    s[7] = (q_rx.size() > 0);
    s[6] = (q_tx.size() < DEPTH);
    return s;
  endfunction

  function automatic logic [31:0] model_access(input logic rd, input logic wr, input logic [4:0] addr,
                                               input logic [31:0] wdata, input logic push_en,
                                               input logic [7:0] push_b);
    logic [31:0] r;
    int pre_rx;
    r      = 32'h0;
    pre_rx = q_rx.size();
    if (wr) begin
      if (addr == 5'd4) begin
        if (q_tx.size() < DEPTH) q_tx.push_back(wdata[7:0]);
        else m_ovf = 1'b1;
      end else if (addr == 5'd8) begin
        if (wdata[8]) m_ovf = 1'b0;
        if (wdata[9]) m_udf = 1'b0;
      end
    end else if (rd) begin
      if (addr == 5'd0) begin
        if (pre_rx > 0) r = {24'h0, q_rx.pop_front()};
        else m_udf = 1'b1;
      end else if (addr == 5'd8) begin
        r = status_model();
      end
    end
    if (push_en && pre_rx < DEPTH) q_rx.push_back(push_b);
    return r;
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic push_en, input logic [7:0] push_b, input string tag);
    logic [31:0] exp_v;
    int n;
    exp_v = model_access(rd, wr, addr, wdata, push_en, push_b);
    @(negedge avm_clk);
    avm_read = rd; avm_write = wr; avm_address = addr; avm_writedata = wdata;
    rx_valid = push_en; rx_data = push_b;
    n = 0;
    do begin
      @(negedge avm_clk);
      n++;
    end while (avm_waitrequest && n < 8);
    chk({tag, "_lat"}, 32'(n), 32'd1);
    chk(tag, avm_readdata, exp_v);
    avm_read = 1'b0; avm_write = 1'b0; rx_valid = 1'b0;
    @(negedge avm_clk);
    chk({tag, "_wr_hi"}, {31'h0, avm_waitrequest}, 32'd1);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge avm_clk);
    rx_valid = 1'b1; rx_data = b;
    chk("rx_ready", {31'h0, rx_ready}, {31'h0, q_rx.size() < DEPTH});
    if (q_rx.size() < DEPTH) q_rx.push_back(b);
    @(negedge avm_clk);
    rx_valid = 1'b0;
  endtask

  task automatic tx_pop_check();
    @(negedge avm_clk);
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, q_tx.size() > 0});
    chk("tx_data", {24'h0, tx_data}, {24'h0, (q_tx.size() > 0) ? q_tx[0] : 8'h00});
    tx_ready = 1'b1;
    if (q_tx.size() > 0) void'(q_tx.pop_front());
    @(negedge avm_clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    avm_rst = 1'b1; avm_address = '0; avm_read = 1'b0; avm_write = 1'b0; avm_writedata = '0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge avm_clk);
    chk("rst_wr", {31'h0, avm_waitrequest}, 32'd1);
    avm_rst = 1'b0;
    @(negedge avm_clk);
    chk("rst_wr_post", {31'h0, avm_waitrequest}, 32'd1);
    chk("rst_rd", avm_readdata, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'd1);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    access(1, 0, 5'd8, 0, 0, 0, "status_reset");

    rx_push(8'hA5);
    rx_push(8'h3C);
    access(1, 0, 5'd8, 0, 0, 0, "status_2rx");
    access(1, 0, 5'd0, 0, 0, 0, "rx_a5");
    access(1, 0, 5'd0, 0, 0, 0, "rx_3c");
    access(1, 0, 5'd8, 0, 0, 0, "status_drained");

    // Master holds read high, alternating STATUS and RX while the line side streams 32 bytes.
    fed = 0; got = 0; last = -1; cyc = 0; fc = 0;
    fork
      begin
        while (fed < 32 && fc < 4000) begin
          @(negedge avm_clk);
          fc++;
          rx_valid = 1'b1; rx_data = 8'(fed);
          if (rx_ready) fed++;
        end
        @(negedge avm_clk);
        rx_valid = 1'b0;
      end
      begin
        @(negedge avm_clk);
        cur = 5'd8; avm_address = cur; avm_read = 1'b1;
        while (got < 32 && cyc < 4000) begin
          @(negedge avm_clk);
          cyc++;
          if (!avm_waitrequest) begin
            if (last >= 0) chk("hold_spacing", 32'(cyc - last), 32'd2);
            last = cyc;
            if (cur == 5'd0) begin
              chk("hold_rx", avm_readdata, 32'(got));
              got++;
              cur = 5'd8;
            end else if (avm_readdata[7]) begin
              cur = 5'd0;
            end
            avm_address = cur;
          end
        end
        avm_read = 1'b0;
        chk("hold_count", 32'(got), 32'd32);
      end
    join
    @(negedge avm_clk);

    for (int i = 0; i < 16; i++) access(0, 1, 5'd4, 32'(8'h11 + i), 0, 0, "tx_fill");
    access(0, 1, 5'd4, 32'h99, 0, 0, "tx_over");
    access(1, 0, 5'd8, 0, 0, 0, "status_ovf");
    for (int i = 0; i < 17; i++) tx_pop_check();
    access(0, 1, 5'd8, 32'h100, 0, 0, "clr_ovf");
    access(1, 0, 5'd8, 0, 0, 0, "status_clr_ovf");

    access(1, 0, 5'd0, 0, 0, 0, "rx_empty_rd");
    access(1, 0, 5'd8, 0, 0, 0, "status_udf");
    for (int i = 0; i < 17; i++) rx_push(8'($urandom));
    access(1, 0, 5'd0, 0, 1, 8'hE1, "rx_full_pushpop");
    access(1, 0, 5'd0, 0, 1, 8'hE2, "rx_15_pushpop");
    rx_push(8'hE3);
    rx_push(8'hE4);
    access(1, 0, 5'd8, 0, 0, 0, "status_full");
    for (int i = 0; i < 17; i++) access(1, 0, 5'd0, 0, 0, 0, "rx_drain");
    access(0, 1, 5'd8, 32'h200, 0, 0, "clr_udf");

    for (int i = 0; i < 3; i++) rx_push(8'($urandom));
    for (int i = 0; i < 2; i++) access(0, 1, 5'd4, $urandom, 0, 0, "tx_pre_rst");
    @(negedge avm_clk);
    avm_address = 5'd8; avm_read = 1'b1;
    @(negedge avm_clk);
    chk("pre_rst_resp", {31'h0, avm_waitrequest}, 32'd0);
    #2 avm_rst = 1'b1;
    #1;
    chk("arst_wr", {31'h0, avm_waitrequest}, 32'd1);
    chk("arst_rd", avm_readdata, 32'h0);
    chk("arst_rx_ready", {31'h0, rx_ready}, 32'd1);
    chk("arst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("arst_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge avm_clk);
    avm_read = 1'b0;
    avm_rst = 1'b0;
    q_rx.delete(); q_tx.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    access(1, 0, 5'd8, 0, 0, 0, "status_after_rst");

    for (int i = 0; i < 400; i++) begin
      int op, kind;
      logic [4:0] a;
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0, 1:    a = 5'd0;
        2, 3:    a = 5'd8;
        4, 5:    a = 5'd4;
        6:       a = 5'd12;
        default: a = 5'($urandom);
      endcase
      if (op <= 2) rx_push(8'($urandom));
      else if (op == 3) tx_pop_check();
      else begin
        kind = $urandom_range(0, 3);
        case (kind)
          0:       access(1, 0, a, $urandom, 0, 0, "rnd_rd");
          1:       access(0, 1, a, $urandom, 0, 0, "rnd_wr");
          2:       access(1, 1, a, $urandom, 0, 0, "rnd_rdwr");
          default: access(1, 0, a, $urandom, 1, 8'($urandom), "rnd_rd_push");
        endcase
      end
    end
    access(1, 0, 5'd8, 0, 0, 0, "status_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
